fetch_pc: RTL and testbench

- Program-counter and instruction-fetch stage sitting directly upstream of the instruction decoder.
- Drives the memory address bus (MAB) for program ROM and captures the returned word (MDB_out) into an instruction register. The decoder consumes that register.
- Updates the PC according to the decoder's MPC select: hold, increment, load, or conditional jump.
- On reset, performs the MSP430 reset-vector fetch from 0xFFFE before normal sequential fetch begins.

---
 rtl/fetch_pc_if.sv | 61 ++++++
 rtl/fetch_pc.sv | 202 ++++++++++++++++++++
 tb/tb_fetch_pc.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_if.sv
// -----------------------------------------------------------------------------
// fetch_pc_if
//
// Purpose:
//   Bundles the signals between the PC/fetch stage, the instruction decoder
//   and program memory.
//
// Signals:
//   MPC          3   PC select from decoder (0 hold, 1 inc, 2 load, 3 cond jump)
//   jcond        3   jump condition code (decoder FS[2:0])
//   SR_flags     4   status flags {V,N,Z,C}
//   PC_load      16  load target for MPC=2
//   MDB_out      16  word returned by program memory for MAB
//   MAB          16  program memory address
//   PC           16  current program counter
//   IR           16  last captured instruction/extension word
//   fetch_valid  1   IR holds a word from the sequential stream
//   jump_taken   1   one-cycle pulse after a taken conditional jump
//
// Modports:
//   slave  : the fetch stage itself (consumes control/data, drives MAB/PC/IR)
//   master : the surrounding decoder + memory
// -----------------------------------------------------------------------------
interface fetch_pc_if;
  logic [2:0]  MPC;
  logic [2:0]  jcond;
  logic [3:0]  SR_flags;
  logic [15:0] PC_load;
  logic [15:0] MDB_out;
  logic [15:0] MAB;
  logic [15:0] PC;
  logic [15:0] IR;
  logic        fetch_valid;
  logic        jump_taken;

  modport slave (
    input  MPC,
    input  jcond,
    input  SR_flags,
    input  PC_load,
    input  MDB_out,
    output MAB,
    output PC,
    output IR,
    output fetch_valid,
    output jump_taken
  );

  modport master (
    output MPC,
    output jcond,
    output SR_flags,
    output PC_load,
    output MDB_out,
    input  MAB,
    input  PC,
    input  IR,
    input  fetch_valid,
    input  jump_taken
  );
endinterface : fetch_pc_if

// File: rtl/fetch_pc.sv
// -----------------------------------------------------------------------------
// fetch_pc
//
// Purpose:
//   Program counter and instruction-fetch stage ahead of the decoder. After
//   reset it fetches the reset vector from RST_VEC, loads it into the PC, and
//   then fetches sequentially, loading or jumping as the decoder requests.
//
// Ports:
//   clk   in   system clock, all state updates on posedge
//   rst   in   asynchronous, active-high reset
//   bus   slave modport of fetch_pc_if:
//           in : MPC, jcond, SR_flags, PC_load, MDB_out
//           out: MAB, PC, IR, fetch_valid, jump_taken
//
// Parameters:
//   RST_VEC  address of the reset vector word
//   PC_RST   PC value held while reset is asserted
// -----------------------------------------------------------------------------
module fetch_pc #(
  parameter logic [15:0] RST_VEC = 16'hFFFE,
  parameter logic [15:0] PC_RST  = 16'h0000
) (
  input  logic       clk,
  input  logic       rst,
  fetch_pc_if.slave  bus
);

  // ---------------------------------------------------------------------------
  // Types and constants
  // ---------------------------------------------------------------------------
  typedef enum logic {
    S_VEC = 1'b0,   // fetching the reset vector
    S_RUN = 1'b1    // normal program fetch
  } state_e;

  localparam logic [2:0] MPC_HOLD = 3'd0;
  localparam logic [2:0] MPC_INC  = 3'd1;
  localparam logic [2:0] MPC_LOAD = 3'd2;
  localparam logic [2:0] MPC_JMP  = 3'd3;

  localparam logic [2:0] JC_JNE = 3'b000;
  localparam logic [2:0] JC_JEQ = 3'b001;
  localparam logic [2:0] JC_JNC = 3'b010;
  localparam logic [2:0] JC_JC  = 3'b011;
  localparam logic [2:0] JC_JN  = 3'b100;
  localparam logic [2:0] JC_JGE = 3'b101;
  localparam logic [2:0] JC_JL  = 3'b110;
  localparam logic [2:0] JC_JMP = 3'b111;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e      state_q,       state_d;
  logic [15:0] pc_q,          pc_d;
  logic [15:0] ir_q,          ir_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic        jump_taken_q,  jump_taken_d;

  // ---------------------------------------------------------------------------
  // Jump condition evaluation.
  // Returns {known, taken}. An unrecognised (X/Z) condition code drops to the
  // default arm and reports known=0 so the caller can hold the PC instead of
  // letting X reach it.
  // ---------------------------------------------------------------------------
  function automatic logic [1:0] eval_cond(input logic [2:0] jc,
                                           input logic [3:0] flags);
    logic v, n, z, c;
    logic [1:0] res;
    {v, n, z, c} = flags;
    res = 2'b00;
    case (jc)
      JC_JNE:  res = {1'b1, ~z};
      JC_JEQ:  res = {1'b1,  z};
      JC_JNC:  res = {1'b1, ~c};
      JC_JC:   res = {1'b1,  c};
      JC_JN:   res = {1'b1,  n};
      JC_JGE:  res = {1'b1, ~(n ^ v)};
      JC_JL:   res = {1'b1,  (n ^ v)};
      JC_JMP:  res = 2'b11;
      default: res = 2'b00;
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------
  logic [15:0] pc_inc;
  logic [15:0] jump_offset;
  logic [15:0] pc_jump;
  logic [15:0] pc_load_even;
  logic [15:0] vec_even;
  logic        cond_known;
  logic        cond_taken;

  // All PC arithmetic wraps modulo 2^16; 0xFFFE + 2 = 0x0000 is legal.
  assign pc_inc       = pc_q + 16'd2;

  // Offset comes from the jump word in IR: 10-bit signed word count, doubled
  // into a byte offset and sign-extended to 16 bits. PC already points one
  // word past the jump word, giving the MSP430 target A + 2 + 2*offset.
  assign jump_offset  = {{5{ir_q[9]}}, ir_q[9:0], 1'b0};
  assign pc_jump      = pc_q + jump_offset;

  // Instruction addresses are word aligned; bit 0 is always dropped.
  assign pc_load_even = {bus.PC_load[15:1], 1'b0};
  assign vec_even     = {bus.MDB_out[15:1], 1'b0};

  assign {cond_known, cond_taken} = eval_cond(bus.jcond, bus.SR_flags);

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    fetch_valid_d = 1'b0;
    jump_taken_d  = 1'b0;

    case (state_q)
      S_VEC: begin
        // Memory is returning the reset vector word; it becomes the PC.
        pc_d    = vec_even;
        state_d = S_RUN;
      end

      S_RUN: begin
        case (bus.MPC)
          MPC_INC: begin
            ir_d          = bus.MDB_out;
            pc_d          = pc_inc;
            fetch_valid_d = 1'b1;
          end

          MPC_LOAD: begin
            // The word fetched at the old PC is captured but flagged invalid.
            ir_d = bus.MDB_out;
            pc_d = pc_load_even;
          end

          MPC_JMP: begin
            if (!cond_known) begin
              // Unknown condition code: hold, as for MPC 0/4-7.
              pc_d = pc_q;
            end else if (cond_taken) begin
              pc_d         = pc_jump;
              jump_taken_d = 1'b1;
            end else begin
              ir_d          = bus.MDB_out;
              pc_d          = pc_inc;
              fetch_valid_d = 1'b1;
            end
          end

          // MPC_HOLD, 4-7, and any X/Z select: PC and IR hold.
          default: begin
            pc_d = pc_q;
          end
        endcase
      end

      default: begin
        state_d = S_VEC;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_VEC;
      pc_q          <= PC_RST;
      ir_q          <= 16'h0000;
      fetch_valid_q <= 1'b0;
      jump_taken_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      fetch_valid_q <= fetch_valid_d;
      jump_taken_q  <= jump_taken_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. MAB is combinational so it follows the PC in the same cycle.
  // ---------------------------------------------------------------------------
  assign bus.MAB         = (state_q == S_VEC) ? RST_VEC : pc_q;
  assign bus.PC          = pc_q;
  assign bus.IR          = ir_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.jump_taken  = jump_taken_q;

endmodule : fetch_pc

// File: tb/tb_fetch_pc.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc
//
// Directed bench for fetch_pc. Inputs change 1 ns after each rising edge and
// outputs are sampled at that same point, well away from the next edge. The
// program memory is represented by setting MDB_out to the word expected at
// the current MAB in each step.
// -----------------------------------------------------------------------------
module tb_fetch_pc;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  fetch_pc_if bus ();

  fetch_pc #(
    .RST_VEC (16'hFFFE),
    .PC_RST  (16'h0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Load the PC with base, fetch the jump word there, then issue MPC=3.
  task automatic do_jump(input string tag, input logic [15:0] base,
                         input logic [15:0] word, input logic [2:0] jc,
                         input logic [3:0] flags, input logic taken,
                         input logic [15:0] exp_pc);
    bus.MPC     = 3'd2;
    bus.PC_load = base;
    bus.MDB_out = 16'hDEAD;
    tick();
    bus.MPC     = 3'd1;
    bus.MDB_out = word;
    tick();
    check({tag, "_ir"}, bus.IR, word);
    bus.MPC      = 3'd3;
    bus.jcond    = jc;
    bus.SR_flags = flags;
    bus.MDB_out  = 16'h5A5A;
    tick();
    check({tag, "_pc"}, bus.PC, exp_pc);
    check({tag, "_jt"}, {15'd0, bus.jump_taken}, {15'd0, taken});
    check({tag, "_fv"}, {15'd0, bus.fetch_valid}, {15'd0, ~taken});
    bus.MPC = 3'd0;
    tick();
    check({tag, "_jt_clr"}, {15'd0, bus.jump_taken}, 16'd0);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;

    // ---------------- reset and vector fetch ----------------
    rst          = 1'b1;
    bus.MPC      = 3'd0;
    bus.jcond    = 3'd0;
    bus.SR_flags = 4'd0;
    bus.PC_load  = 16'h0000;
    bus.MDB_out  = 16'hC001;
    tick();
    tick();
    check("rst_pc",  bus.PC, 16'h0000);
    check("rst_ir",  bus.IR, 16'h0000);
    check("rst_mab", bus.MAB, 16'hFFFE);
    check("rst_fv",  {15'd0, bus.fetch_valid}, 16'd0);
    check("rst_jt",  {15'd0, bus.jump_taken}, 16'd0);

    rst = 1'b0;
    check("vec_mab", bus.MAB, 16'hFFFE);
    tick();
    check("vec_pc",  bus.PC, 16'hC000);
    check("vec_mab2", bus.MAB, 16'hC000);
    check("vec_fv",  {15'd0, bus.fetch_valid}, 16'd0);
    check("vec_ir",  bus.IR, 16'h0000);

    // ---------------- sequential fetch ----------------
    bus.MPC     = 3'd1;
    bus.MDB_out = 16'h4031;
    tick();
    check("seq1_ir", bus.IR, 16'h4031);
    check("seq1_pc", bus.PC, 16'hC002);
    bus.MDB_out = 16'h0400;
    tick();
    check("seq2_ir", bus.IR, 16'h0400);
    check("seq2_mab", bus.MAB, 16'hC004);
    bus.MDB_out = 16'h4303;
    tick();
    check("seq3_ir", bus.IR, 16'h4303);
    check("seq3_pc", bus.PC, 16'hC006);
    check("seq3_fv", {15'd0, bus.fetch_valid}, 16'd1);

    // ---------------- hold (MPC 0, 5, 7) ----------------
    bus.MPC     = 3'd0;
    bus.MDB_out = 16'hBEEF;
    tick();
    check("hold0_pc", bus.PC, 16'hC006);
    check("hold0_ir", bus.IR, 16'h4303);
    check("hold0_fv", {15'd0, bus.fetch_valid}, 16'd0);
    bus.MPC = 3'd5;
    tick();
    check("hold5_pc", bus.PC, 16'hC006);
    bus.MPC = 3'd7;
    tick();
    check("hold7_pc", bus.PC, 16'hC006);
    check("hold7_ir", bus.IR, 16'h4303);

    // ---------------- JNE taken / not taken ----------------
    // 0x23FE at 0xC010: offset -2 words -> 0xC012 - 4 = 0xC00E
    do_jump("jne_t",  16'hC010, 16'h23FE, 3'b000, 4'b0000, 1'b1, 16'hC00E);
    do_jump("jne_nt", 16'hC010, 16'h23FE, 3'b000, 4'b0010, 1'b0, 16'hC014);
    // Not taken behaves as an increment: the next word is captured.
    check("jne_nt_ir", bus.IR, 16'h5A5A);

    // ---------------- JGE / JL over {N,V}; offset +5 words ----------------
    // base 0xC100, jump word 0x3405 -> target 0xC102 + 10 = 0xC10C
    do_jump("jge_00", 16'hC100, 16'h3405, 3'b101, 4'b0000, 1'b1, 16'hC10C);
    do_jump("jge_01", 16'hC100, 16'h3405, 3'b101, 4'b1000, 1'b0, 16'hC104);
    do_jump("jge_10", 16'hC100, 16'h3405, 3'b101, 4'b0100, 1'b0, 16'hC104);
    do_jump("jge_11", 16'hC100, 16'h3405, 3'b101, 4'b1100, 1'b1, 16'hC10C);
    do_jump("jl_00",  16'hC100, 16'h3805, 3'b110, 4'b0000, 1'b0, 16'hC104);
    do_jump("jl_01",  16'hC100, 16'h3805, 3'b110, 4'b1000, 1'b1, 16'hC10C);
    do_jump("jl_10",  16'hC100, 16'h3805, 3'b110, 4'b0100, 1'b1, 16'hC10C);
    do_jump("jl_11",  16'hC100, 16'h3805, 3'b110, 4'b1100, 1'b0, 16'hC104);

    // ---------------- remaining conditions ----------------
    do_jump("jeq_t",  16'hC100, 16'h2405, 3'b001, 4'b0010, 1'b1, 16'hC10C);
    do_jump("jnc_nt", 16'hC100, 16'h2805, 3'b010, 4'b0001, 1'b0, 16'hC104);
    do_jump("jc_t",   16'hC100, 16'h2C05, 3'b011, 4'b0001, 1'b1, 16'hC10C);
    do_jump("jn_nt",  16'hC100, 16'h3005, 3'b100, 4'b1011, 1'b0, 16'hC104);

    // ---------------- JMP offset 0 and offset extremes ----------------
    do_jump("jmp0",   16'hC020, 16'h3C00, 3'b111, 4'b0000, 1'b1, 16'hC022);
    // offset -512 words: 0xC102 - 0x400 = 0xBD02
    do_jump("jmp_min", 16'hC100, 16'h3E00, 3'b111, 4'b1111, 1'b1, 16'hBD02);
    // offset +511 words: 0xC102 + 0x3FE = 0xC500
    do_jump("jmp_max", 16'hC100, 16'h3DFF, 3'b111, 4'b0000, 1'b1, 16'hC500);

    // ---------------- load and wrap ----------------
    bus.MPC     = 3'd2;
    bus.PC_load = 16'h1235;
    bus.MDB_out = 16'h7777;
    tick();
    check("load_pc", bus.PC, 16'h1234);
    check("load_fv", {15'd0, bus.fetch_valid}, 16'd0);
    check("load_ir", bus.IR, 16'h7777);

    bus.PC_load = 16'hFFFE;
    tick();
    check("wrap_pre_mab", bus.MAB, 16'hFFFE);
    bus.MPC     = 3'd1;
    bus.MDB_out = 16'h1234;
    tick();
    check("wrap_pc", bus.PC, 16'h0000);
    check("wrap_ir", bus.IR, 16'h1234);

    // ---------------- async reset mid-jump ----------------
    bus.MPC     = 3'd2;
    bus.PC_load = 16'hC020;
    tick();
    bus.MPC     = 3'd1;
    bus.MDB_out = 16'h3C00;
    tick();
    bus.MPC   = 3'd3;
    bus.jcond = 3'b111;
    #2;
    rst = 1'b1;
    #1;
    // No clock edge has occurred since rst rose.
    check("arst_pc",  bus.PC, 16'h0000);
    check("arst_ir",  bus.IR, 16'h0000);
    check("arst_mab", bus.MAB, 16'hFFFE);
    check("arst_jt",  {15'd0, bus.jump_taken}, 16'd0);
    tick();
    check("arst_hold_pc", bus.PC, 16'h0000);
    bus.MDB_out = 16'hC001;
    rst = 1'b0;
    check("revec_mab", bus.MAB, 16'hFFFE);
    tick();
    check("revec_pc",  bus.PC, 16'hC000);
    check("revec_mab2", bus.MAB, 16'hC000);
    check("revec_jt",  {15'd0, bus.jump_taken}, 16'd0);
    check("revec_fv",  {15'd0, bus.fetch_valid}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_fetch_pc
